// File: rtl/iter_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per enabled clock, WIDTH steps per product.
// Signed mode weights the multiplier MSB negatively, so the last step subtracts instead of adds.
module iter_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic            r_signed;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [PW-1:0]   r_product;

  logic [PW-1:0]   w_a_ext;
  logic [PW-1:0]   w_acc_next;
  logic            w_last;

  // Operand extension and the accumulator update for the current multiplier bit
  always_comb begin
    w_a_ext    = {PW{1'b0}};
    w_acc_next = r_acc;
    w_last     = (r_cnt == LAST_STEP);
    if (signed_mode) begin
      w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    end else begin
      w_a_ext = {{WIDTH{1'b0}}, a};
    end
    if (r_mplier[0]) begin
      if (r_signed && w_last) begin
        w_acc_next = r_acc - r_mcand;
      end else begin
        w_acc_next = r_acc + r_mcand;
      end
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Control FSM and datapath registers; everything holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= {PW{1'b0}};
      r_mcand     <= {PW{1'b0}};
      r_mplier    <= {WIDTH{1'b0}};
      r_signed    <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_product   <= {PW{1'b0}};
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= S_CALC;
            r_acc      <= {PW{1'b0}};
            r_mcand    <= w_a_ext;
            r_mplier   <= b;
            r_signed   <= signed_mode;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_product   <= w_acc_next;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_product   <= {PW{1'b0}};
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_product   <= {PW{1'b0}};
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign busy      = r_busy;

endmodule
